// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock through a full adder
// built from two half-adder cells, with a start/busy/done handshake.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one operand bit summed per cycle, LSB first
// DONE  | sum/cout just updated; done pulses for this one cycle
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_nxt;
    logic             c_ff;
    logic [CW-1:0]    cnt;
    logic             s1;
    logic             c1;
    logic             s_bit;
    logic             c2;
    logic             c_next;
    logic             last_bit;

    half_adder u_ha1 (.x(a_sr[0]), .y(b_sr[0]), .s(s1),    .c(c1));
    half_adder u_ha2 (.x(s1),      .y(c_ff),    .s(s_bit), .c(c2));

    assign c_next   = c1 | c2;
    assign last_bit = (cnt == LAST);
    // Shift-in form written so it stays legal when WIDTH is 1.
    assign r_nxt    = (r_sr >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            c_ff <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        c_ff <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_nxt;
                    c_ff <= c_next;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= r_nxt;
                        cout <= c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake/timing
// cases and a 4-bit instance swept over every operand pair.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8;
    logic [7:0] a8, b8, sum8;
    logic       cout8, busy8, done8;
    logic       start4;
    logic [3:0] a4, b4, sum4;
    logic       cout4, busy4, done4;

    int n_vec = 0;
    int n_err = 0;
    int n_done4 = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
    );

    always @(negedge clk) if (done4) n_done4++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input string tag);
        logic [8:0] exp;
        logic [7:0] held;
        logic       held_ok;
        int         cyc;
        int         bcnt;
        exp = {1'b0, av} + {1'b0, bv};
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        held = sum8;
        @(negedge clk);
        start8 = 1'b0; a8 = ~av; b8 = ~bv;
        cyc = 0; bcnt = 0; held_ok = 1'b1;
        while (!done8 && cyc < 30) begin
            if (busy8) bcnt++;
            if (sum8 !== held) held_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, 8);
        chk({tag, " busy cycles"}, bcnt, 8);
        chk({tag, " prior sum held"}, held_ok, 1);
        chk({tag, " result"}, {cout8, sum8}, exp);
        chk({tag, " busy at done"}, busy8, 0);
        @(negedge clk);
        chk({tag, " done one cycle"}, done8, 0);
    endtask

    initial begin
        int cyc;
        int gap;
        int extra;
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;

        #100;
        chk("reset outputs", {sum8, cout8, busy8, done8}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post reset idle", {sum8, cout8, busy8, done8}, 0);

        run8(8'h03, 8'h05, "add 03+05");
        run8(8'hFF, 8'h01, "add FF+01");
        run8(8'hA5, 8'h5A, "add A5+5A");
        run8(8'hFF, 8'hFF, "add FF+FF");

        // start held high through RUN and DONE: back-to-back additions only.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        cyc = 0;
        while (!done8 && cyc < 30) begin @(negedge clk); cyc++; end
        chk("held start first latency", cyc, 9);
        chk("held start first result", {cout8, sum8}, 9'h046);
        @(negedge clk);
        gap = 1;
        while (!done8 && gap < 30) begin @(negedge clk); gap++; end
        start8 = 1'b0;
        chk("done spacing", gap, 10);
        chk("held start second result", {cout8, sum8}, 9'h046);
        extra = 0;
        repeat (14) begin @(negedge clk); if (done8) extra++; end
        chk("no queued addition", extra, 0);

        // Reset three cycles into RUN.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy before reset", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset outputs", {sum8, cout8, busy8, done8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin @(negedge clk); if (done8 || busy8) extra++; end
        chk("no done after reset", extra, 0);
        chk("sum cleared after reset", {cout8, sum8}, 0);
        run8(8'h10, 8'h20, "add 10+20");

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                @(negedge clk);
                a4 = ai[3:0]; b4 = bi[3:0]; start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                cyc = 0;
                while (!done4 && cyc < 20) begin @(negedge clk); cyc++; end
                chk($sformatf("w4 %0d+%0d", ai, bi), {cout4, sum4}, ai + bi);
            end
        end
        @(negedge clk);
        chk("w4 done pulse count", n_done4, 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder that adds two WIDTH-bit operands LSB-first, one bit per clock. Each bit is summed by a full adder built from two half-adder cells, with the carry held in a flip-flop between cycles. It sits directly downstream of the half-adder cell and consumes its sum/carry outputs. Its start/busy/done handshake lets a controller or testbench sequence multi-bit additions through a single adder slice.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.

- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- sum  output  WIDTH  registered result; holds the last completed sum
- cout  output  1  registered carry-out of the last completed addition
- busy  output  1  high while an addition is in progress (RUN)
- done  output  1  one-cycle pulse when sum/cout are updated

## Operation
- Internal state:
  - a_sr and b_sr: WIDTH-bit operand shift registers.
  - r_sr: WIDTH-bit result shift register.
  - c_ff: carry flip-flop.
  - cnt: bit counter, ceil(log2(WIDTH+1)) bits wide.
  - FSM with states IDLE, RUN, DONE.
- Bit datapath:
  - Half adder 1: x=a_sr[0], y=b_sr[0] gives s1, c1.
  - Half adder 2: x=s1, y=c_ff gives s_bit, c2.
  - c_next = c1 | c2.
- IDLE:
  - If start=1: load a_sr<=a, b_sr<=b, c_ff<=0, cnt<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, every cycle:
  - Shift a_sr and b_sr right by 1, with zero fill.
  - r_sr <= {s_bit, r_sr[WIDTH-1:1]}.
  - c_ff <= c_next.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1: copy the final r_sr value (including this cycle's s_bit) into sum, set cout<=c_next, go to DONE.
- DONE: done=1 for exactly this state; unconditionally go to IDLE next cycle.
- start is ignored in RUN and DONE. A request in those states is dropped, not queued.
- sum and cout change only on the RUN→DONE transition and hold between additions. Partial results are never visible on sum.
- Arithmetic: {cout,sum} = a + b, unsigned, modulo 2^(WIDTH+1). No overflow flag beyond cout.
- Reset (asynchronous, any state, including mid-RUN):
  - State → IDLE.
  - sum=0, cout=0, busy=0, done=0.
  - All shift registers, c_ff and cnt = 0.
  - An in-flight addition is discarded.
- After rst_n deasserts, the first rising edge with start=1 begins a new addition normally.

## Timing
- Edge E0 samples start=1 in IDLE. After E0: state=RUN, busy=1.
- Edges E1..EWIDTH process bits 0..WIDTH-1.
- After edge EWIDTH: state=DONE, busy=0, done=1, sum/cout valid.
- After edge EWIDTH+1: state=IDLE, done=0. The next start is accepted at EWIDTH+2 at the earliest.
- Latency from accepting edge to done: WIDTH cycles. Throughput: one addition per WIDTH+2 cycles.
- busy and done are registered (Moore) outputs decoded from state; they are never high together.
- Operand inputs a and b are don't-care except at the accepting edge.
- WIDTH=1: RUN lasts a single cycle; done is asserted after E1.

## Test plan
- Reset: rst_n=0 with clk running → sum=0x00, cout=0, busy=0, done=0. Hold for 100 ns, release, and check that outputs remain 0 with start=0.
- Basic add, WIDTH=8: a=0x03, b=0x05, start pulse → busy high for 8 cycles, done pulse on the 9th state, sum=0x08, cout=0.
- Carry ripple: a=0xFF, b=0x01 → sum=0x00, cout=1. Then a=0xA5, b=0x5A → sum=0xFF, cout=0, with the previous result held until this done.
- Ignored start: start held high during RUN and DONE → exactly one addition completes. The next is accepted only on the first edge back in IDLE; check done pulse spacing is WIDTH+2 cycles.
- Reset mid-operation: a=0xFF, b=0xFF, assert rst_n=0 after 3 RUN cycles → immediate sum=0, cout=0, busy=0, no done pulse. A fresh add of 0x10+0x20 then yields 0x30.
- Exhaustive check with WIDTH=4: all 256 (a,b) pairs → {cout,sum} == a+b in every case, with no lost or duplicate done pulses.
